if_prefetch_queue: RTL and testbench
====================================

// Module: if_prefetch_queue
// PURPOSE
//  Parametrised instruction-fetch stage with an instruction prefetch queue, replacing fixed PC-mux fetch.
//  Generates PC and drives instruction-memory address/enable; the memory has fixed 1-cycle read latency.
//  Buffers returned words with their PCs in a DEPTH-entry FIFO; ID consumes via valid/ready.
//  Supports CP0 exception flush and branch/jump redirect, both discarding in-flight and queued fetches.
// PARAMETERS
//  ADDR_W   32            width of PC / instruction address
//  INST_W   32            width of instruction word
//  DEPTH    4             prefetch queue entries; power of 2, >= 2
//  PC_INIT  32'h00000000  PC value after reset; also iaddr value when ice = 0
// PORTS
//  cpu_clk_50M  in   1       clock; all state updates on rising edge
//  cpu_rst      in   1       synchronous reset, active-high
//  flush        in   1       CP0 exception flush; highest priority
//  cp0_excaddr  in   ADDR_W  exception handler address, sampled when flush = 1
//  redir_valid  in   1       branch/jump taken, from ID
//  redir_addr   in   ADDR_W  branch/jump target, sampled when redir_valid = 1 && flush = 0
//  ice          out  1       instruction-memory chip enable (read request this cycle)
//  iaddr        out  ADDR_W  instruction-memory address; = pc when ice = 1, else PC_INIT
//  irdata       in   INST_W  instruction word; valid the cycle after ice = 1
//  id_valid     out  1       queue head holds a valid instruction
//  id_ready     in   1       ID accepts head this cycle
//  id_pc        out  ADDR_W  PC of head entry
//  id_inst      out  INST_W  instruction of head entry
// BEHAVIOUR
//  - Reset (cpu_rst = 1 at edge): pc <= PC_INIT, queue empty, inflight <= 0, ce <= 0.
//    Outputs while in reset and first cycle after: ice = 0, iaddr = PC_INIT, id_valid = 0.
//  - ce register: goes 1 the cycle after reset deasserts; gates all issue.
//  - Issue: ice = ce && !flush && !redir_valid && (count + inflight < DEPTH). Combinational.
//  - On ice = 1: inflight <= 1, pc <= pc + 4 (mod 2^ADDR_W), tag register <= pc. Else inflight <= 0.
//  - Response: cycle after issue (inflight = 1), {tag, irdata} pushed at the tail, unless killed.
//  - Pop: id_valid && id_ready removes head. Push + pop in same cycle: count unchanged, both pointers advance.
//  - Credit rule guarantees no push when full; no overflow logic needed (assert in sim: push && full never occurs).
//  - id_valid = (count != 0); id_pc/id_inst driven from head entry, registered storage, no bypass.
//    Latency: ice at cycle t -> id_valid at t+2 (empty queue).
//  - Redirect (priority: flush > redir_valid > sequential), applied at the edge ending the cycle in which it is asserted:
//    pc <= cp0_excaddr (flush) or redir_addr (redir); queue cleared (count, pointers <= 0);
//    response arriving that cycle is discarded; inflight <= 0; pop ignored.
//    ice = 0 during that cycle; fetch from the new pc is issued the next cycle.
//  - flush and redir_valid both high: flush wins, redir_addr ignored.
//  - Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits, range 0..DEPTH.
//  - Reset mid-operation: overrides everything; inflight response discarded; queue cleared.
//  - Steady state with id_ready = 1: one instruction per cycle, ice continuously high.
//  - id_ready low: queue fills to DEPTH, then ice drops; issue resumes the cycle after the first pop frees credit.
// TESTING
//  1 Reset release, id_ready=1, mem returns irdata=addr^32'hFFFF0000 -> ice high from 2nd cycle;
//    id_pc sequence 0,4,8,... one per cycle; id_inst matches.
//  2 id_ready=0 for 10 cycles -> exactly DEPTH(4) entries buffered (id_pc 0..12) and ice=0;
//    id_ready=1 -> entries drain in order, no loss or duplicate.
//  3 redir_valid=1, redir_addr=32'h100 while queue holds 3 entries and one in flight ->
//    next cycle id_valid=0; first delivered id_pc=32'h100; stale PCs never appear.
//  4 flush=1, cp0_excaddr=32'h4180 in the same cycle as redir_valid=1, redir_addr=32'h200 ->
//    first delivered id_pc=32'h4180.
//  5 cpu_rst=1 with full queue mid-stream -> id_valid=0 and iaddr=PC_INIT next cycle;
//    after release, first id_pc=PC_INIT.
//  6 Random id_ready plus random redirects (DEPTH=2 and 8) against a reference model ->
//    PC order matches; never push when full; never pop when empty.

Source files
------------

// File: rtl/if_prefetch_queue_if.sv
`default_nettype none
// ============================================================================
// Interface   : if_prefetch_queue_if
// Description : Fetch-stage bundle. Carries the redirect inputs (CP0 flush,
//               branch/jump redirect), the instruction-memory port and the
//               valid/ready hand-off of fetched instructions to ID.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_prefetch_queue_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32
);
  // Redirect sources
  logic              flush;
  logic [ADDR_W-1:0] cp0_excaddr;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_addr;

  // Instruction memory, fixed 1-cycle read latency
  logic              ice;
  logic [ADDR_W-1:0] iaddr;
  logic [INST_W-1:0] irdata;

  // Hand-off to ID
  logic              id_valid;
  logic              id_ready;
  logic [ADDR_W-1:0] id_pc;
  logic [INST_W-1:0] id_inst;

  // Fetch-stage side
  modport master (
    input  flush, cp0_excaddr, redir_valid, redir_addr, irdata, id_ready,
    output ice, iaddr, id_valid, id_pc, id_inst
  );

  // Environment side: CP0, ID and instruction memory
  modport slave (
    output flush, cp0_excaddr, redir_valid, redir_addr, irdata, id_ready,
    input  ice, iaddr, id_valid, id_pc, id_inst
  );
endinterface
`default_nettype wire

// File: rtl/if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_prefetch_queue
// Description : Instruction-fetch stage with a DEPTH-entry prefetch queue.
//               Issues sequential fetches under a credit check so that the
//               single in-flight response always has room in the queue.
//               CP0 flush and branch/jump redirect drop queued and in-flight
//               fetches and restart the PC.
// Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch_queue #(
  parameter int unsigned       ADDR_W  = 32,
  parameter int unsigned       INST_W  = 32,
  parameter int unsigned       DEPTH   = 4,
  parameter logic [ADDR_W-1:0] PC_INIT = '0
) (
  input  wire logic           cpu_clk_50M,
  input  wire logic           cpu_rst,
  if_prefetch_queue_if.master bus
);

  localparam int unsigned        c_PTR_W   = $clog2(DEPTH);
  localparam int unsigned        c_CNT_W   = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0]  c_PC_STEP = ADDR_W'(4);

  logic               r_ce;
  logic [ADDR_W-1:0]  r_pc;
  logic               r_inflight;
  logic [ADDR_W-1:0]  r_tag;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [ADDR_W-1:0]  r_q_pc   [DEPTH];
  logic [INST_W-1:0]  r_q_inst [DEPTH];

  logic               w_redirect;
  logic [ADDR_W-1:0]  w_redir_pc;
  logic               w_has_credit;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;

  // Flush outranks a branch redirect; redir_addr is ignored when both fire.
  assign w_redirect = bus.flush | bus.redir_valid;
  assign w_redir_pc = bus.flush ? bus.cp0_excaddr : bus.redir_addr;

  // Counting the in-flight fetch against the queue reserves a slot for its
  // response, so a push can never find the queue full. The sum is at most
  // DEPTH+1, which still fits in the count width.
  assign w_has_credit = (r_count + c_CNT_W'(r_inflight)) < c_DEPTH;

  // No request is made while reset is held so memory sees a quiet port.
  assign w_issue = r_ce && !cpu_rst && !w_redirect && w_has_credit;

  // A redirect kills the response landing this cycle and any pop by ID.
  assign w_push = r_inflight && !w_redirect && !cpu_rst;
  assign w_pop  = (r_count != '0) && bus.id_ready && !w_redirect && !cpu_rst;

  assign bus.ice      = w_issue;
  assign bus.iaddr    = w_issue ? r_pc : PC_INIT;
  assign bus.id_valid = (r_count != '0);
  assign bus.id_pc    = r_q_pc[r_rd_ptr];
  assign bus.id_inst  = r_q_inst[r_rd_ptr];

  // PC generation, issue enable and the tag of the outstanding fetch.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      r_ce       <= 1'b0;
      r_pc       <= PC_INIT;
      r_inflight <= 1'b0;
      r_tag      <= PC_INIT;
    end else begin
      r_ce       <= 1'b1;
      r_inflight <= w_issue;
      if (w_redirect) begin
        r_pc <= w_redir_pc;
      end else if (w_issue) begin
        r_pc  <= r_pc + c_PC_STEP;
        r_tag <= r_pc;
      end
    end
  end

  // Queue pointers and occupancy; reset and redirect empty the queue.
  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst || w_redirect) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage: each returned word is stored with the PC it was fetched from.
  always_ff @(posedge cpu_clk_50M) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]   <= r_tag;
      r_q_inst[r_wr_ptr] <= bus.irdata;
    end
  end

  // A push into a full queue would mean the credit check is broken.
  a_no_push_when_full : assert property (
    @(posedge cpu_clk_50M) disable iff (cpu_rst) !(w_push && (r_count == c_DEPTH))
  );

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_prefetch_queue
// Description : Self-checking bench for if_prefetch_queue. Three instances
//               (DEPTH 4, 2 and 8) share one stimulus stream; each has its
//               own 1-cycle memory model and a scoreboard of expected PCs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_prefetch_queue;

  localparam logic [31:0] PC_INIT  = 32'h0000_0000;
  localparam logic [31:0] INST_KEY = 32'hFFFF_0000;
  localparam int          NDUT     = 3;
  localparam int          DEPTH_A  = 4;
  localparam int          DEPTH_B  = 2;
  localparam int          DEPTH_C  = 8;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst     = 1'b1;
  logic        flush       = 1'b0;
  logic        redir_valid = 1'b0;
  logic        id_ready    = 1'b0;
  logic [31:0] cp0_excaddr = '0;
  logic [31:0] redir_addr  = '0;

  int tests_run    = 0;
  int tests_failed = 0;

  always #10 cpu_clk_50M = ~cpu_clk_50M;

  if_prefetch_queue_if #(.ADDR_W(32), .INST_W(32)) b0 ();
  if_prefetch_queue_if #(.ADDR_W(32), .INST_W(32)) b1 ();
  if_prefetch_queue_if #(.ADDR_W(32), .INST_W(32)) b2 ();

  assign b0.flush = flush;  assign b0.cp0_excaddr = cp0_excaddr;  assign b0.redir_valid = redir_valid;
  assign b0.redir_addr = redir_addr;  assign b0.id_ready = id_ready;
  assign b1.flush = flush;  assign b1.cp0_excaddr = cp0_excaddr;  assign b1.redir_valid = redir_valid;
  assign b1.redir_addr = redir_addr;  assign b1.id_ready = id_ready;
  assign b2.flush = flush;  assign b2.cp0_excaddr = cp0_excaddr;  assign b2.redir_valid = redir_valid;
  assign b2.redir_addr = redir_addr;  assign b2.id_ready = id_ready;

  // Instruction memory: word at address A is A ^ INST_KEY, one cycle later.
  always @(posedge cpu_clk_50M) b0.irdata <= b0.iaddr ^ INST_KEY;
  always @(posedge cpu_clk_50M) b1.irdata <= b1.iaddr ^ INST_KEY;
  always @(posedge cpu_clk_50M) b2.irdata <= b2.iaddr ^ INST_KEY;

  if_prefetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH_A), .PC_INIT(PC_INIT)) u_dut_a (
    .cpu_clk_50M(cpu_clk_50M), .cpu_rst(cpu_rst), .bus(b0));
  if_prefetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH_B), .PC_INIT(PC_INIT)) u_dut_b (
    .cpu_clk_50M(cpu_clk_50M), .cpu_rst(cpu_rst), .bus(b1));
  if_prefetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH_C), .PC_INIT(PC_INIT)) u_dut_c (
    .cpu_clk_50M(cpu_clk_50M), .cpu_rst(cpu_rst), .bus(b2));

  // Observed values and model expectations for the current cycle
  int          depth_of [NDUT] = '{DEPTH_A, DEPTH_B, DEPTH_C};
  logic        obs_ice [NDUT];
  logic        obs_valid [NDUT];
  logic [31:0] obs_iaddr [NDUT];
  logic [31:0] obs_pc [NDUT];
  logic [31:0] obs_inst [NDUT];
  logic        exp_ice [NDUT];
  logic        exp_valid [NDUT];
  logic [31:0] exp_iaddr [NDUT];
  logic        popped [NDUT];
  logic [31:0] exp_pop_pc [NDUT];
  logic        sb_underflow [NDUT];
  logic        over_full [NDUT];
  int          pop_count [NDUT];

  // Reference model state
  int          occ [NDUT];
  logic        pend [NDUT];
  logic        ce_m [NDUT];
  logic [31:0] pc_m [NDUT];
  logic [31:0] next_push [NDUT];

  // Scoreboards of PCs expected at the ID hand-off
  logic [31:0] sbq0 [$];
  logic [31:0] sbq1 [$];
  logic [31:0] sbq2 [$];

  task automatic sb_push(input int k, input logic [31:0] v);
    case (k)
      0:       sbq0.push_back(v);
      1:       sbq1.push_back(v);
      default: sbq2.push_back(v);
    endcase
  endtask

  task automatic sb_pop(input int k, output logic [31:0] v, output logic ok);
    v  = '0;
    ok = 1'b1;
    case (k)
      0:       if (sbq0.size() == 0) ok = 1'b0; else v = sbq0.pop_front();
      1:       if (sbq1.size() == 0) ok = 1'b0; else v = sbq1.pop_front();
      default: if (sbq2.size() == 0) ok = 1'b0; else v = sbq2.pop_front();
    endcase
  endtask

  // A new fetch stream starts at base; queued expectations are stale.
  task automatic sb_restart(input int k, input logic [31:0] base);
    case (k)
      0:       sbq0.delete();
      1:       sbq1.delete();
      default: sbq2.delete();
    endcase
    for (int i = 0; i < 4; i++) sb_push(k, base + 32'(4 * i));
    next_push[k] = base + 32'd16;
  endtask

  // Sample one cycle at the falling edge, update the model for the coming
  // rising edge, then return just after that edge so inputs can be driven.
  task automatic advance();
    logic [31:0] v;
    logic        ok;
    @(negedge cpu_clk_50M);
    obs_ice[0] = b0.ice; obs_iaddr[0] = b0.iaddr; obs_valid[0] = b0.id_valid;
    obs_pc[0]  = b0.id_pc; obs_inst[0] = b0.id_inst;
    obs_ice[1] = b1.ice; obs_iaddr[1] = b1.iaddr; obs_valid[1] = b1.id_valid;
    obs_pc[1]  = b1.id_pc; obs_inst[1] = b1.id_inst;
    obs_ice[2] = b2.ice; obs_iaddr[2] = b2.iaddr; obs_valid[2] = b2.id_valid;
    obs_pc[2]  = b2.id_pc; obs_inst[2] = b2.id_inst;
    for (int k = 0; k < NDUT; k++) begin
      exp_ice[k]   = ce_m[k] && !cpu_rst && !flush && !redir_valid &&
                     ((occ[k] + (pend[k] ? 1 : 0)) < depth_of[k]);
      exp_iaddr[k] = exp_ice[k] ? pc_m[k] : PC_INIT;
      exp_valid[k] = (occ[k] != 0);
      popped[k]    = obs_valid[k] && id_ready && !flush && !redir_valid && !cpu_rst;
      sb_underflow[k] = 1'b0;
      exp_pop_pc[k]   = '0;
      if (popped[k]) begin
        sb_pop(k, v, ok);
        exp_pop_pc[k]   = v;
        sb_underflow[k] = !ok;
        sb_push(k, next_push[k]);
        next_push[k] = next_push[k] + 32'd4;
        pop_count[k]++;
      end
      if (cpu_rst) begin
        occ[k] = 0; pend[k] = 1'b0; ce_m[k] = 1'b0; pc_m[k] = PC_INIT;
        sb_restart(k, PC_INIT);
      end else if (flush || redir_valid) begin
        occ[k] = 0; pend[k] = 1'b0; ce_m[k] = 1'b1;
        pc_m[k] = flush ? cp0_excaddr : redir_addr;
        sb_restart(k, pc_m[k]);
      end else begin
        occ[k]  = occ[k] + (pend[k] ? 1 : 0) - (popped[k] ? 1 : 0);
        pend[k] = obs_ice[k];
        ce_m[k] = 1'b1;
        if (obs_ice[k]) pc_m[k] = pc_m[k] + 32'd4;
      end
      over_full[k] = (occ[k] > depth_of[k]);
    end
    @(posedge cpu_clk_50M);
    #1;
  endtask

  task automatic test_reset();
    cpu_rst = 1'b1; flush = 1'b0; redir_valid = 1'b0; id_ready = 1'b0;
    advance();
    advance();
    tests_run++;
    if ({obs_ice[0], obs_valid[0]} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_outputs: ice=%b id_valid=%b, want 0 0", obs_ice[0], obs_valid[0]);
    end
    tests_run++;
    if (obs_iaddr[0] !== PC_INIT) begin
      tests_failed++; $display("FAIL reset_iaddr: got %h want %h", obs_iaddr[0], PC_INIT);
    end
    cpu_rst  = 1'b0;
    id_ready = 1'b1;
    advance();
    tests_run++;
    if ({obs_ice[0], obs_valid[0]} !== 2'b00) begin
      tests_failed++; $display("FAIL post_reset_outputs: ice=%b id_valid=%b, want 0 0", obs_ice[0], obs_valid[0]);
    end
    tests_run++;
    if (obs_iaddr[0] !== PC_INIT) begin
      tests_failed++; $display("FAIL post_reset_iaddr: got %h want %h", obs_iaddr[0], PC_INIT);
    end
  endtask

  task automatic test_stream();
    int start_pops;
    start_pops = pop_count[0];
    for (int i = 0; i < 14; i++) begin
      advance();
      tests_run++;
      if ({obs_ice[0], obs_valid[0], obs_iaddr[0]} !== {1'b1, exp_valid[0], exp_iaddr[0]}) begin
        tests_failed++;
        $display("FAIL stream_cycle %0d: ice=%b valid=%b iaddr=%h, want ice=1 valid=%b iaddr=%h",
                 i, obs_ice[0], obs_valid[0], obs_iaddr[0], exp_valid[0], exp_iaddr[0]);
      end
      if (popped[0]) begin
        tests_run++;
        if (sb_underflow[0] || {obs_pc[0], obs_inst[0]} !== {exp_pop_pc[0], exp_pop_pc[0] ^ INST_KEY}) begin
          tests_failed++;
          $display("FAIL stream_pop: got pc=%h inst=%h, want pc=%h inst=%h",
                   obs_pc[0], obs_inst[0], exp_pop_pc[0], exp_pop_pc[0] ^ INST_KEY);
        end
      end
    end
    tests_run++;
    if (pop_count[0] - start_pops !== 12) begin
      tests_failed++; $display("FAIL stream_rate: got %0d pops want 12", pop_count[0] - start_pops);
    end
  endtask

  task automatic test_backpressure();
    int start_pops;
    cpu_rst = 1'b1; id_ready = 1'b0;
    advance();
    cpu_rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      advance();
      tests_run++;
      if ({obs_ice[0], obs_valid[0], obs_iaddr[0], over_full[0]} !==
          {exp_ice[0], exp_valid[0], exp_iaddr[0], 1'b0}) begin
        tests_failed++;
        $display("FAIL bp_fill_cycle %0d: ice=%b valid=%b iaddr=%h occ=%0d, want ice=%b valid=%b iaddr=%h",
                 i, obs_ice[0], obs_valid[0], obs_iaddr[0], occ[0], exp_ice[0], exp_valid[0], exp_iaddr[0]);
      end
    end
    tests_run++;
    if ({obs_ice[0], obs_valid[0], obs_pc[0]} !== {1'b0, 1'b1, PC_INIT} || occ[0] != DEPTH_A) begin
      tests_failed++;
      $display("FAIL bp_full: ice=%b valid=%b head=%h buffered=%0d, want ice=0 valid=1 head=%h buffered=%0d",
               obs_ice[0], obs_valid[0], obs_pc[0], occ[0], PC_INIT, DEPTH_A);
    end
    id_ready   = 1'b1;
    start_pops = pop_count[0];
    for (int i = 0; i < 10; i++) begin
      advance();
      if (i < 2) begin
        tests_run++;
        if (obs_ice[0] !== (i == 1)) begin
          tests_failed++; $display("FAIL bp_resume %0d: ice=%b want %b", i, obs_ice[0], (i == 1));
        end
      end
      if (popped[0]) begin
        tests_run++;
        if (sb_underflow[0] || {obs_pc[0], obs_inst[0]} !== {exp_pop_pc[0], exp_pop_pc[0] ^ INST_KEY}) begin
          tests_failed++;
          $display("FAIL bp_drain_pop: got pc=%h inst=%h, want pc=%h inst=%h",
                   obs_pc[0], obs_inst[0], exp_pop_pc[0], exp_pop_pc[0] ^ INST_KEY);
        end
      end
    end
    tests_run++;
    if (pop_count[0] - start_pops !== 10) begin
      tests_failed++; $display("FAIL bp_drain_count: got %0d pops want 10", pop_count[0] - start_pops);
    end
  endtask

  // Drive one redirect cycle, check the cycle after, then wait for the
  // first delivered instruction and check it is the new target.
  task automatic test_redirect_case(input string name, input logic do_flush, input logic do_redir,
                                    input logic [31:0] exc, input logic [31:0] tgt,
                                    input logic [31:0] want_pc);
    logic got;
    flush = do_flush; cp0_excaddr = exc; redir_valid = do_redir; redir_addr = tgt;
    advance();
    tests_run++;
    if (obs_ice[0] !== 1'b0) begin
      tests_failed++; $display("FAIL %s_ice_during: got %b want 0", name, obs_ice[0]);
    end
    flush = 1'b0; redir_valid = 1'b0;
    advance();
    tests_run++;
    if ({obs_valid[0], obs_ice[0], obs_iaddr[0]} !== {1'b0, 1'b1, want_pc}) begin
      tests_failed++;
      $display("FAIL %s_after: valid=%b ice=%b iaddr=%h, want valid=0 ice=1 iaddr=%h",
               name, obs_valid[0], obs_ice[0], obs_iaddr[0], want_pc);
    end
    id_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      advance();
      if (popped[0]) begin
        got = 1'b1;
        tests_run++;
        if ({obs_pc[0], obs_inst[0]} !== {want_pc, want_pc ^ INST_KEY}) begin
          tests_failed++;
          $display("FAIL %s_first_pc: got pc=%h inst=%h, want pc=%h inst=%h",
                   name, obs_pc[0], obs_inst[0], want_pc, want_pc ^ INST_KEY);
        end
      end
    end
    tests_run++;
    if (!got) begin
      tests_failed++; $display("FAIL %s_timeout: got no delivery in 10 cycles, want one", name);
    end
    for (int i = 0; i < 6; i++) begin
      advance();
      if (popped[0]) begin
        tests_run++;
        if (sb_underflow[0] || obs_pc[0] !== exp_pop_pc[0]) begin
          tests_failed++; $display("FAIL %s_follow_pc: got %h want %h", name, obs_pc[0], exp_pop_pc[0]);
        end
      end
    end
  endtask

  task automatic test_redirect();
    logic found;
    cpu_rst = 1'b1; id_ready = 1'b0;
    advance();
    cpu_rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      advance();
      if (occ[0] == 3 && pend[0]) found = 1'b1;
    end
    tests_run++;
    if (!found) begin
      tests_failed++; $display("FAIL redir_setup: got buffered=%0d inflight=%b, want 3 and 1", occ[0], pend[0]);
    end
    test_redirect_case("redir", 1'b0, 1'b1, 32'h0, 32'h0000_0100, 32'h0000_0100);
  endtask

  task automatic test_flush_priority();
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) advance();
    test_redirect_case("flush", 1'b1, 1'b1, 32'h0000_4180, 32'h0000_0200, 32'h0000_4180);
  endtask

  task automatic test_reset_midstream();
    logic full;
    logic got;
    id_ready = 1'b0;
    full = 1'b0;
    for (int i = 0; i < 12 && !full; i++) begin
      advance();
      if (occ[0] == DEPTH_A) full = 1'b1;
    end
    tests_run++;
    if (!full) begin
      tests_failed++; $display("FAIL rst_mid_setup: got buffered=%0d want %0d", occ[0], DEPTH_A);
    end
    cpu_rst = 1'b1;
    advance();
    cpu_rst = 1'b0;
    advance();
    tests_run++;
    if ({obs_valid[0], obs_ice[0], obs_iaddr[0]} !== {1'b0, 1'b0, PC_INIT}) begin
      tests_failed++;
      $display("FAIL rst_mid_after: valid=%b ice=%b iaddr=%h, want 0 0 %h",
               obs_valid[0], obs_ice[0], obs_iaddr[0], PC_INIT);
    end
    id_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      advance();
      if (popped[0]) begin
        got = 1'b1;
        tests_run++;
        if (obs_pc[0] !== PC_INIT) begin
          tests_failed++; $display("FAIL rst_mid_first_pc: got %h want %h", obs_pc[0], PC_INIT);
        end
      end
    end
    tests_run++;
    if (!got) begin
      tests_failed++; $display("FAIL rst_mid_timeout: got no delivery in 10 cycles, want one");
    end
  endtask

  task automatic test_random();
    int r;
    int start_pops [NDUT];
    for (int k = 0; k < NDUT; k++) start_pops[k] = pop_count[k];
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (((cyc / 40) % 2) == 1) id_ready = ($urandom_range(0, 3) == 0);
      else                       id_ready = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 63));
      cp0_excaddr = 32'($urandom_range(0, 16383)) << 2;
      redir_addr  = (r == 3) ? 32'hFFFF_FFF8 : (32'($urandom_range(0, 16383)) << 2);
      flush       = (r == 0) || (r == 1);
      redir_valid = (r >= 1) && (r <= 4);
      cpu_rst     = (r == 63) && ($urandom_range(0, 3) == 0);
      advance();
      for (int k = 0; k < NDUT; k++) begin
        tests_run++;
        if ({obs_ice[k], obs_valid[k], obs_iaddr[k], over_full[k]} !==
            {exp_ice[k], exp_valid[k], exp_iaddr[k], 1'b0}) begin
          tests_failed++;
          $display("FAIL rand_cycle dut%0d cyc %0d: ice=%b valid=%b iaddr=%h occ=%0d, want ice=%b valid=%b iaddr=%h occ<=%0d",
                   k, cyc, obs_ice[k], obs_valid[k], obs_iaddr[k], occ[k],
                   exp_ice[k], exp_valid[k], exp_iaddr[k], depth_of[k]);
        end
        if (popped[k]) begin
          tests_run++;
          if (sb_underflow[k] || {obs_pc[k], obs_inst[k]} !== {exp_pop_pc[k], exp_pop_pc[k] ^ INST_KEY}) begin
            tests_failed++;
            $display("FAIL rand_pop dut%0d cyc %0d: got pc=%h inst=%h, want pc=%h inst=%h",
                     k, cyc, obs_pc[k], obs_inst[k], exp_pop_pc[k], exp_pop_pc[k] ^ INST_KEY);
          end
        end
      end
    end
    flush = 1'b0; redir_valid = 1'b0; cpu_rst = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      tests_run++;
      if (pop_count[k] - start_pops[k] < 50) begin
        tests_failed++;
        $display("FAIL rand_progress dut%0d: got %0d pops want at least 50", k, pop_count[k] - start_pops[k]);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      occ[k] = 0; pend[k] = 1'b0; ce_m[k] = 1'b0; pc_m[k] = PC_INIT; pop_count[k] = 0;
      sb_restart(k, PC_INIT);
    end
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_flush_priority();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test by 1000000 time units, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
